// File: rtl/gray_deco_arbiter.sv
// Round-robin time-sharing of one external Gray-to-binary decoder; accept->rsp_valid 2 cycles, rsp_ready low stalls in RESP.
// Optional per-requester Gray step check under GRAY_STEP_CHK_EN (step_err tied 0 otherwise).
module gray_deco_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [4*N_REQ-1:0]   req_gray,
    output logic [N_REQ-1:0]     req_ready,
    output logic [3:0]           dec_gray,
    input  logic [3:0]           dec_bin,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [3:0]           rsp_bin,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic                 step_err
);

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] ptr_next;
    logic           found;

    // First set request at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) req_ready[winner] = 1'b1;
    end

    assign ptr_next = (int'(rsp_id) == N_REQ - 1) ? '0 : rsp_id + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            dec_gray  <= 4'd0;
            rsp_id    <= '0;
            rsp_bin   <= 4'd0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        dec_gray <= req_gray[4*int'(winner) +: 4];
                        rsp_id   <= winner;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    rsp_bin   <= dec_bin;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        ptr       <= ptr_next;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef GRAY_STEP_CHK_EN
    logic [3:0]       last_code [N_REQ];
    logic [N_REQ-1:0] hist;

    // A repeated code is legal; only two or more flipped bits flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist     <= '0;
            step_err <= 1'b0;
            for (int i = 0; i < N_REQ; i++) last_code[i] <= 4'd0;
        end else if (state == CONV) begin
            step_err          <= hist[rsp_id] && ($countones(dec_gray ^ last_code[rsp_id]) >= 2);
            last_code[rsp_id] <= dec_gray;
            hist[rsp_id]      <= 1'b1;
        end
    end
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_deco_arbiter.sv
// Randomised and directed scoreboard bench for gray_deco_arbiter.
module tb_gray_deco_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [4*N-1:0] req_gray;
    logic [N-1:0]   req_ready;
    logic [3:0]     dec_gray;
    logic [3:0]     dec_bin;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [3:0]     rsp_bin;
    logic           rsp_ready;
    logic           busy;
    logic           step_err;

    gray_deco_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
        .req_ready(req_ready), .dec_gray(dec_gray), .dec_bin(dec_bin),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bin(rsp_bin),
        .rsp_ready(rsp_ready), .busy(busy), .step_err(step_err)
    );

    always #5 clk = ~clk;

    // External shared decoder.
    assign dec_bin = {dec_gray[3], ^dec_gray[3:2], ^dec_gray[3:1], ^dec_gray[3:0]};

    typedef struct {
        int id;
        int bin;
        int err;
        int t;
        bit seen;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   pending = 0;
    bit   accepted;
    int   rs, cur_id;
    int   ptr_m = 0;
    int   last_m [N];
    bit   hist_m [N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Binary value whose Gray encoding is g.
    function automatic int ref_bin(input int g);
        for (int b = 0; b < 16; b++)
            if ((b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    task automatic cycle_drive(input logic [N-1:0] v, input logic [4*N-1:0] g, input bit r);
        int w;
        int e_rdy;
        int code;
        @(negedge clk);
        cyc++;
        req_valid = v;
        req_gray  = g;
        rsp_ready = r;
        accepted  = 0;
        #1;
        chk("busy", int'(busy), int'(pending));
        w = -1;
        if (!pending)
            for (int k = 0; k < N; k++)
                if (w < 0 && v[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        e_rdy = (w >= 0) ? (1 << w) : 0;
        chk("req_ready", int'(req_ready), e_rdy);
        if (w >= 0) begin
            exp_t e;
            code  = int'(g >> (4 * w)) & 15;
            e.id  = w;
            e.bin = ref_bin(code);
            e.err = 0;
`ifdef GRAY_STEP_CHK_EN
            if (hist_m[w] && $countones(code ^ last_m[w]) >= 2) e.err = 1;
            hist_m[w] = 1;
            last_m[w] = code;
`endif
            e.t    = cyc;
            e.seen = 0;
            q.push_back(e);
            pending  = 1;
            accepted = 1;
            rs       = cyc + 2;
            cur_id   = w;
        end else if (pending && cyc >= rs && r) begin
            pending = 0;
            ptr_m   = (cur_id + 1) % N;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (pending || q.size() > 0); i++) cycle_drive('0, '0, 1'b1);
        if (pending) chk("drain_timeout", 1, 0);
    endtask

    task automatic send(input int id, input int code);
        logic [N-1:0]   v;
        logic [4*N-1:0] g;
        int             n;
        v = '0;
        v[id] = 1'b1;
        g = '0;
        g[4*id +: 4] = code[3:0];
        n = 0;
        do begin
            cycle_drive(v, g, 1'b1);
            n++;
        end while (!accepted && n < 20);
        if (!accepted) chk("accept_timeout", 0, 1);
        drain();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 0);
        chk({tag, "_dec_gray"},  int'(dec_gray), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_id"},    int'(rsp_id), 0);
        chk({tag, "_rsp_bin"},   int'(rsp_bin), 0);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_step_err"},  int'(step_err), 0);
    endtask

    // Monitor: compares each presented response against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (rsp_valid) begin
            if (q.size() == 0 || cyc < q[0].t + 2) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                if (!q[0].seen) begin
                    chk("rsp_latency", cyc, q[0].t + 2);
                    q[0].seen = 1;
                end
                chk("rsp_id", int'(rsp_id), q[0].id);
                chk("rsp_bin", int'(rsp_bin), q[0].bin);
                chk("step_err", int'(step_err), q[0].err);
                if (rsp_ready) void'(q.pop_front());
            end
        end else if (rst_n && q.size() > 0 && !q[0].seen && cyc >= q[0].t + 2) begin
            chk("rsp_valid_late", 0, 1);
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_gray  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            last_m[i] = 0;
            hist_m[i] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesters continuously valid: grants 0,1,2,3,0.
        for (int i = 0; i < 15; i++) cycle_drive(4'hF, {4'b0010, 4'b0011, 4'b0001, 4'b0000}, 1'b1);
        drain();

        send(2, 4'b1000);

        // Backpressure, with competing requests held high while stalled.
        cycle_drive(4'b0010, 16'h0070, 1'b1);
        for (int i = 0; i < 7; i++) cycle_drive(4'hF, 16'hFFFF, 1'b0);
        drain();

        for (int g = 0; g < 16; g++) send(1, g);

        // Reset asserted while the accepted transaction is in CONV.
        cycle_drive(4'b1000, 16'h5000, 1'b1);
        @(negedge clk);
        cyc++;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        q.delete();
        pending = 0;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            last_m[i] = 0;
            hist_m[i] = 0;
        end
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        cycle_drive(4'b1001, 16'h3000, 1'b1);
        drain();

        send(0, 4'b0000);
        send(0, 4'b0001);
        send(0, 4'b0111);
        send(0, 4'b0111);

        for (int i = 0; i < 1500; i++)
            cycle_drive(N'($urandom_range(0, 15)), (4*N)'($urandom), ($urandom_range(0, 3) != 0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
